// File: rtl/multiword_adder_seq_if.sv
// rtl/multiword_adder_seq_if.sv - operand/result handshake bundle for the sliced multi-word adder
interface multiword_adder_seq_if #(
   parameter int WIDTH = 128
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, op, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, op, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/multiword_adder_seq.sv
// rtl/multiword_adder_seq.sv - WIDTH-bit add through one CHUNK-bit slice per cycle, carry rippled in a register
// Optional subtract (a + ~b + 1) when ADDSEQ_SUB_EN is defined.
module multiword_adder_seq #(
   parameter int WIDTH = 128,
   parameter int CHUNK = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multiword_adder_seq_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                       state, state_nxt;
   logic [NCHUNK-1:0][CHUNK-1:0] a_q, b_q, sum_q;
   logic                         carry_q, cout_q;
   logic [IDXW-1:0]              idx_q;
   logic [CHUNK:0]               slice;
   logic                         last_slice;
   logic                         accept;
   logic [WIDTH-1:0]             b_in;
   logic                         carry_in;

`ifdef ADDSEQ_SUB_EN
   assign b_in     = bus.op ? ~bus.b : bus.b;
   assign carry_in = bus.op ? 1'b1 : bus.cin;
`else
   logic op_unused;
   assign op_unused = bus.op;
   assign b_in      = bus.b;
   assign carry_in  = bus.cin;
`endif

   assign slice      = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {{CHUNK{1'b0}}, carry_q};
   assign last_slice = (idx_q == IDXW'(NCHUNK - 1));
   assign accept     = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Accepting during the DONE->IDLE handshake keeps the op spacing at NCHUNK+1 cycles.
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = RUN;
         end
         RUN: begin
            bus.busy = 1'b1;
            if (last_slice) state_nxt = DONE;
         end
         DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            bus.in_ready  = bus.out_ready;
            if (bus.out_ready) state_nxt = bus.in_valid ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         a_q     <= bus.a;
         b_q     <= b_in;
         carry_q <= carry_in;
         idx_q   <= '0;
      end else if (state == RUN) begin
         sum_q[idx_q] <= slice[CHUNK-1:0];
         carry_q      <= slice[CHUNK];
         idx_q        <= idx_q + 1'b1;
         if (last_slice) cout_q <= slice[CHUNK];
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_multiword_adder_seq.sv
// tb/tb_multiword_adder_seq.sv - randomized self-checking bench for multiword_adder_seq against an arithmetic model
module tb_multiword_adder_seq;
   localparam int WIDTH  = 128;
   localparam int CHUNK  = 32;
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int TMO    = 50;
`ifdef ADDSEQ_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multiword_adder_seq_if #(.WIDTH(WIDTH)) bus ();

   multiword_adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // {cout,sum} as plain wide arithmetic; subtract gives {no-borrow, a-b}.
   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic c, input logic o);
      logic [WIDTH-1:0] d;
      if (SUB_EN && o) begin
         d = a - b;
         return {(a >= b), d};
      end
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
   endfunction

   function automatic logic [WIDTH-1:0] rand_w();
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c, input logic o);
      bus.a   = a;
      bus.b   = b;
      bus.cin = c;
      bus.op  = o;
   endtask

   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c, input logic o);
      int n;
      drive(a, b, c, o);
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < TMO) begin
         @(negedge clk);
         n++;
      end
      if (n >= TMO) check("accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < TMO) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic run_one(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic o, output logic [WIDTH:0] res);
      int lat;
      start_op(a, b, c, o);
      wait_done(lat);
      check({tag, "_lat"}, lat, NCHUNK);
      res = {bus.cout, bus.sum};
      check(tag, res, ref_add(a, b, c, o));
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [WIDTH:0]   res, exp1;
      logic [WIDTH-1:0] ra, rb, ones;
      logic             rc, ro;
      int               lat, n, acc, prev;

      ones          = '1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_sum_cout", {bus.cout, bus.sum}, 0);

      run_one("max_plus1", ones, 1, 1'b0, 1'b0, res);
      check("max_plus1_const", res, {1'b1, {WIDTH{1'b0}}});
      run_one("slice_carry", 128'hFFFF_FFFF, 0, 1'b1, 1'b0, res);
      check("slice_carry_const", res, {1'b0, 128'h1_0000_0000});

`ifdef ADDSEQ_SUB_EN
      run_one("sub_5_3", 5, 3, 1'b0, 1'b1, res);
      check("sub_5_3_const", res, {1'b1, 128'd2});
      run_one("sub_3_5", 3, 5, 1'b1, 1'b1, res);
      check("sub_3_5_const", res, {1'b0, ones - 128'd1});
`else
      run_one("op_ignored", 5, 3, 1'b0, 1'b1, res);
      check("op_ignored_const", res, 129'd8);
`endif

      // Backpressure: result held in DONE while new operands wait.
      ra = rand_w();
      rb = rand_w();
      start_op(ra, rb, 1'b1, 1'b0);
      wait_done(lat);
      exp1 = ref_add(ra, rb, 1'b1, 1'b0);
      check("bp_first", {bus.cout, bus.sum}, exp1);
      ra = rand_w();
      rb = rand_w();
      drive(ra, rb, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold", {bus.cout, bus.sum}, exp1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_out_valid", bus.out_valid, 1);
      end
      drain();
      n = 0;
      while (!(bus.busy && !bus.out_valid) && n < TMO) begin
         @(negedge clk);
         n++;
      end
      check("bp_reaccept", n < TMO, 1);
      bus.in_valid = 1'b0;
      wait_done(lat);
      check("bp_second", {bus.cout, bus.sum}, ref_add(ra, rb, 1'b0, 1'b0));
      drain();

      // Reset while RUN is about to compute slice 2.
      start_op(rand_w(), rand_w(), 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_sum_cout", {bus.cout, bus.sum}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_in_ready", bus.in_ready, 1);
      run_one("after_rst", 7, 9, 1'b0, 1'b0, res);
      check("after_rst_const", res, 129'd16);

      // Back-to-back with in_valid and out_ready held high.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      prev = 0;
      for (int i = 0; i < 20; i++) begin
         ra = rand_w();
         rb = ($urandom_range(0, 3) == 0) ? ~ra : rand_w();
         rc = 1'($urandom_range(0, 1));
         ro = 1'($urandom_range(0, 1));
         drive(ra, rb, rc, ro);
         n = 0;
         while (!bus.in_ready && n < TMO) begin
            @(negedge clk);
            n++;
         end
         if (n >= TMO) check("b2b_accept_timeout", 1'b0, 1'b1);
         @(posedge clk);
         @(negedge clk);
         acc = cyc;
         if (i > 0) check("b2b_spacing", acc - prev, NCHUNK + 1);
         prev = acc;
         wait_done(lat);
         check("b2b_lat", lat, NCHUNK);
         check("b2b_result", {bus.cout, bus.sum}, ref_add(ra, rb, rc, ro));
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("final_idle", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
